neighbor_accumulation_buffer: RTL and testbench

- Banked tile accumulator directly downstream of the neighbour-input bank router; consumes its per-bank write vectors (row, column, 8-bit data, enable).
- Adds each write into the stored entry, lane-wise saturating according to bitwidth.
- On request, drains the whole tile in raster order over a valid/ready stream, clearing entries as read.
- Bank mapping is identical to the router: bank = (column + 3*row) mod BANK_COUNT.

---
 rtl/neighbor_accumulation_buffer_pkg.sv | 63 ++++++
 rtl/neighbor_accumulation_buffer_bank.sv | 88 ++++++++
 rtl/neighbor_accumulation_buffer.sv | 232 +++++++++++++++++++++++
 tb/tb_neighbor_accumulation_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/neighbor_accumulation_buffer_pkg.sv
// Shared definitions for the neighbour accumulation buffer: FSM states,
// lane-format encodings, the bank/address mapping shared with the router,
// and the lane-wise saturating adder.
package neighbor_accumulation_buffer_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR      = 2'd0,
    ST_IDLE       = 2'd1,
    ST_DRAIN_WAIT = 2'd2,
    ST_DRAIN      = 2'd3
  } state_t;

  // Lane formats; 2'b11 is deliberately handled like BW_LANE8.
  localparam logic [1:0] BW_LANE8 = 2'b00;
  localparam logic [1:0] BW_LANE4 = 2'b01;
  localparam logic [1:0] BW_LANE2 = 2'b10;

  // Bank owning cell (row, column); must stay identical to the router.
  function automatic int bank_from_rc(input int row, input int column, input int bank_count);
    return (column + 3 * row) % bank_count;
  endfunction

  // Address of cell (row, column) inside its bank: {row, column >> log2(bank_count)}.
  function automatic int local_addr(input int row, input int column, input int tile_size,
                                    input int bank_count);
    return row * (tile_size / bank_count) + column / bank_count;
  endfunction

  // Two's-complement add per lane, each lane clamped to its own range.
  function automatic logic [7:0] lane_sat_add(input logic [7:0] a, input logic [7:0] b,
                                              input logic [1:0] bw);
    logic [7:0]        r;
    logic signed [9:0] s;
    r = '0;
    s = '0;
    case (bw)
      BW_LANE4: begin
        for (int i = 0; i < 2; i++) begin
          s = {{6{a[4*i+3]}}, a[4*i +: 4]} + {{6{b[4*i+3]}}, b[4*i +: 4]};
          if (s > 10'sd7)       r[4*i +: 4] = 4'h7;
          else if (s < -10'sd8) r[4*i +: 4] = 4'h8;
          else                  r[4*i +: 4] = s[3:0];
        end
      end
      BW_LANE2: begin
        for (int i = 0; i < 4; i++) begin
          s = {{8{a[2*i+1]}}, a[2*i +: 2]} + {{8{b[2*i+1]}}, b[2*i +: 2]};
          if (s > 10'sd1)       r[2*i +: 2] = 2'b01;
          else if (s < -10'sd2) r[2*i +: 2] = 2'b10;
          else                  r[2*i +: 2] = s[1:0];
        end
      end
      default: begin
        s = {{2{a[7]}}, a} + {{2{b[7]}}, b};
        if (s > 10'sd127)       r = 8'h7f;
        else if (s < -10'sd128) r = 8'h80;
        else                    r = s[7:0];
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/neighbor_accumulation_buffer_bank.sv
// One accumulation bank: single read port / single write port storage with a
// two-stage read-modify-write pipeline (A: read, B: add and write back),
// forwarding between back-to-back writes to the same entry, and a
// maintenance port used by CLEAR (zero write) and DRAIN (read + zero write).
module accumulation_bank
  import neighbor_accumulation_buffer_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_acc_en,
  input  logic [AW-1:0] i_acc_addr,
  input  logic [7:0]    i_acc_data,
  input  logic [1:0]    i_acc_bw,
  input  logic          i_rd_en,
  input  logic          i_zero_en,
  input  logic [AW-1:0] i_mnt_addr,
  output logic [7:0]    o_rd_data,
  output logic          o_wb_pending
);

  logic [7:0]    r_mem [DEPTH];
  logic [7:0]    r_rdata;

  logic          r_b_valid;
  logic [AW-1:0] r_b_addr;
  logic [7:0]    r_b_data;
  logic [1:0]    r_b_bw;
  logic          r_b_fwd;
  logic [7:0]    r_b_fwd_val;

  logic          w_fwd_hit;
  logic          w_rd_en;
  logic [AW-1:0] w_rd_addr;
  logic [7:0]    w_b_old;
  logic [7:0]    w_b_sum;

  // Stage A reading the entry stage B is writing this cycle would see stale data.
  assign w_fwd_hit = i_acc_en && r_b_valid && (r_b_addr == i_acc_addr);

  // Accumulation and drain never overlap, so one read port serves both.
  assign w_rd_en   = i_acc_en || i_rd_en;
  assign w_rd_addr = i_acc_en ? i_acc_addr : i_mnt_addr;

  assign w_b_old = r_b_fwd ? r_b_fwd_val : r_rdata;
  assign w_b_sum = lane_sat_add(w_b_old, r_b_data, r_b_bw);

  // Storage: registered read, one write per cycle (writeback or zeroing).
  // NOTE: the array has no reset; CLEAR zeroes every address after reset, and a reset on the storage would prevent it mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_rdata <= r_mem[w_rd_addr];
    end
    if (r_b_valid) begin
      r_mem[r_b_addr] <= w_b_sum;
    end else if (i_zero_en) begin
      r_mem[i_mnt_addr] <= '0;
    end
  end

  // Stage A -> stage B pipeline registers, capturing the forwarded sum on a hit.
  // NOTE: state updates use <= so every register samples pre-edge values; with = stage B would see this edge's stage-A update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_b_valid   <= 1'b0;
      r_b_addr    <= '0;
      r_b_data    <= '0;
      r_b_bw      <= BW_LANE8;
      r_b_fwd     <= 1'b0;
      r_b_fwd_val <= '0;
    end else begin
      r_b_valid <= i_acc_en;
      if (i_acc_en) begin
        r_b_addr    <= i_acc_addr;
        r_b_data    <= i_acc_data;
        r_b_bw      <= i_acc_bw;
        r_b_fwd     <= w_fwd_hit;
        r_b_fwd_val <= w_b_sum;
      end
    end
  end

  assign o_rd_data    = r_rdata;
  assign o_wb_pending = r_b_valid;

endmodule

// File: rtl/neighbor_accumulation_buffer.sv
// Banked tile accumulator fed by the neighbour-input bank router. Holds the
// FSM, the clear and drain counters, the drain read mux and a 2-entry skid
// buffer so the drain stream tolerates out_ready dropping at any time.
module neighbor_accumulation_buffer
  import neighbor_accumulation_buffer_pkg::*;
#(
  parameter int  BANK_COUNT = 32,
  parameter int  TILE_SIZE  = 256,
  localparam int RW         = $clog2(TILE_SIZE),
  localparam int BANK_DEPTH = TILE_SIZE * TILE_SIZE / BANK_COUNT,
  localparam int AW         = $clog2(BANK_DEPTH),
  localparam int BKW        = $clog2(BANK_COUNT)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [1:0]    bitwidth,
  input  logic [RW-1:0] buffer_row_write    [BANK_COUNT],
  input  logic [RW-1:0] buffer_column_write [BANK_COUNT],
  input  logic [7:0]    buffer_data_write   [BANK_COUNT],
  input  logic          buffer_write_enable [BANK_COUNT],
  input  logic          drain_start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [7:0]    out_data,
  output logic [RW-1:0] out_row,
  output logic [RW-1:0] out_column,
  output logic          out_last,
  output logic          busy,
  output logic          write_error
);

  typedef struct packed {
    logic [7:0]    data;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic          last;
  } skid_entry_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [AW-1:0]   r_clr_cnt;
  logic [2*RW-1:0] r_drain_idx;
  logic            r_issue_done;

  logic            r_if_valid;
  logic [RW-1:0]   r_if_row;
  logic [RW-1:0]   r_if_col;
  logic [BKW-1:0]  r_if_bank;

  skid_entry_t     r_skid0;
  skid_entry_t     r_skid1;
  logic [1:0]      r_skid_cnt;
  skid_entry_t     w_push_entry;

  logic            r_write_error;

  logic [RW-1:0]   w_issue_row;
  logic [RW-1:0]   w_issue_col;
  logic [BKW-1:0]  w_issue_bank;
  logic [AW-1:0]   w_issue_addr;
  logic [AW-1:0]   w_mnt_addr;
  logic [2:0]      w_occ;
  logic            w_space;
  logic            w_issue;
  logic            w_pop;

  logic [BANK_COUNT-1:0] w_bank_ok;
  logic [BANK_COUNT-1:0] w_acc_en;
  logic [BANK_COUNT-1:0] w_drop;
  logic [BANK_COUNT-1:0] w_rd_sel;
  logic [BANK_COUNT-1:0] w_zero_en;
  logic [BANK_COUNT-1:0] w_wb_pending;
  logic [AW-1:0]         w_acc_addr   [BANK_COUNT];
  logic [7:0]            w_bank_rdata [BANK_COUNT];

  // Drain walks (row, column) row-major with the column in the low bits.
  assign w_issue_row  = r_drain_idx[2*RW-1:RW];
  assign w_issue_col  = r_drain_idx[RW-1:0];
  assign w_issue_bank = BKW'(bank_from_rc(int'(w_issue_row), int'(w_issue_col), BANK_COUNT));
  assign w_issue_addr = AW'(local_addr(int'(w_issue_row), int'(w_issue_col), TILE_SIZE,
                                       BANK_COUNT));
  assign w_mnt_addr   = (r_state == ST_CLEAR) ? r_clr_cnt : w_issue_addr;

  // A read may issue only if its data is guaranteed a skid slot next cycle.
  assign w_pop   = out_valid && out_ready;
  assign w_occ   = 3'(r_skid_cnt) + 3'(r_if_valid) - 3'(w_pop);
  assign w_space = (w_occ < 3'd2);
  assign w_issue = (r_state == ST_DRAIN) && !r_issue_done && w_space;

  for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
    assign w_bank_ok[b]  = (bank_from_rc(int'(buffer_row_write[b]),
                                         int'(buffer_column_write[b]), BANK_COUNT) == b);
    assign w_acc_en[b]   = buffer_write_enable[b] && (r_state == ST_IDLE) && w_bank_ok[b];
    assign w_drop[b]     = buffer_write_enable[b] && !w_acc_en[b];
    assign w_acc_addr[b] = AW'(local_addr(int'(buffer_row_write[b]),
                                          int'(buffer_column_write[b]), TILE_SIZE, BANK_COUNT));
    assign w_rd_sel[b]   = w_issue && (w_issue_bank == BKW'(b));
    assign w_zero_en[b]  = (r_state == ST_CLEAR) || w_rd_sel[b];

    accumulation_bank #(
      .DEPTH (BANK_DEPTH),
      .AW    (AW)
    ) u_bank (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_acc_en     (w_acc_en[b]),
      .i_acc_addr   (w_acc_addr[b]),
      .i_acc_data   (buffer_data_write[b]),
      .i_acc_bw     (bitwidth),
      .i_rd_en      (w_rd_sel[b]),
      .i_zero_en    (w_zero_en[b]),
      .i_mnt_addr   (w_mnt_addr),
      .o_rd_data    (w_bank_rdata[b]),
      .o_wb_pending (w_wb_pending[b])
    );
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_CLEAR;
    else          r_state <= w_state_next;
  end

  // Next-state logic and busy flag.
  // NOTE: every output of this block gets a default first, so no path through the case can infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == AW'(BANK_DEPTH - 1)) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (drain_start) w_state_next = ST_DRAIN_WAIT;
      end
      ST_DRAIN_WAIT: begin
        if (!(|w_wb_pending)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop && r_skid0.last) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_CLEAR;
    endcase
  end

  // Clear address counter; wraps to 0 as CLEAR completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_clr_cnt <= '0;
    else if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
  end

  // Drain issue counter and the single in-flight read tag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drain_idx  <= '0;
      r_issue_done <= 1'b0;
      r_if_valid   <= 1'b0;
      r_if_row     <= '0;
      r_if_col     <= '0;
      r_if_bank    <= '0;
    end else begin
      if (r_state == ST_DRAIN_WAIT) begin
        r_drain_idx  <= '0;
        r_issue_done <= 1'b0;
      end else if (w_issue) begin
        r_drain_idx <= r_drain_idx + 1'b1;
        if (&r_drain_idx) r_issue_done <= 1'b1;
      end
      r_if_valid <= w_issue;
      if (w_issue) begin
        r_if_row  <= w_issue_row;
        r_if_col  <= w_issue_col;
        r_if_bank <= w_issue_bank;
      end
    end
  end

  // Entry pushed into the skid buffer when the read data returns.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.data = w_bank_rdata[r_if_bank];
    w_push_entry.row  = r_if_row;
    w_push_entry.col  = r_if_col;
    w_push_entry.last = (r_if_row == RW'(TILE_SIZE - 1)) && (r_if_col == RW'(TILE_SIZE - 1));
  end

  // Two-entry skid buffer; r_skid0 is the head presented on the outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid0    <= '0;
      r_skid1    <= '0;
      r_skid_cnt <= '0;
    end else begin
      case ({r_if_valid, w_pop})
        2'b10: begin
          if (r_skid_cnt == 2'd0) r_skid0 <= w_push_entry;
          else                    r_skid1 <= w_push_entry;
          r_skid_cnt <= r_skid_cnt + 1'b1;
        end
        2'b01: begin
          r_skid0    <= r_skid1;
          r_skid_cnt <= r_skid_cnt - 1'b1;
        end
        2'b11: begin
          if (r_skid_cnt == 2'd1) begin
            r_skid0 <= w_push_entry;
          end else begin
            r_skid0 <= r_skid1;
            r_skid1 <= w_push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky dropped-write flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     r_write_error <= 1'b0;
    else if (|w_drop) r_write_error <= 1'b1;
  end

  assign out_valid   = (r_skid_cnt != 2'd0);
  assign out_data    = r_skid0.data;
  assign out_row     = r_skid0.row;
  assign out_column  = r_skid0.col;
  assign out_last    = out_valid && r_skid0.last;
  assign write_error = r_write_error;

endmodule

// File: tb/tb_neighbor_accumulation_buffer.sv
// Randomised bench for neighbor_accumulation_buffer (8x8 tile, 4 banks),
// checked against a cell-array model of the tile built from the mapping and
// lane-saturation rules.
module tb_neighbor_accumulation_buffer;

  localparam int BC    = 4;
  localparam int TS    = 8;
  localparam int RW    = 3;
  localparam int DEPTH = TS * TS / BC;
  localparam int N     = TS * TS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    bitwidth = 2'b00;
  logic [RW-1:0] row_w  [BC];
  logic [RW-1:0] col_w  [BC];
  logic [7:0]    data_w [BC];
  logic          we_w   [BC];
  logic          drain_start = 1'b0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [7:0]    out_data;
  logic [RW-1:0] out_row;
  logic [RW-1:0] out_column;
  logic          out_last;
  logic          busy;
  logic          write_error;

  int model [TS][TS];
  bit exp_err;
  int n_tests = 0;
  int n_fail  = 0;
  int prev_r [BC];
  int prev_c [BC];
  bit prev_v [BC];

  neighbor_accumulation_buffer #(
    .BANK_COUNT (BC),
    .TILE_SIZE  (TS)
  ) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .bitwidth            (bitwidth),
    .buffer_row_write    (row_w),
    .buffer_column_write (col_w),
    .buffer_data_write   (data_w),
    .buffer_write_enable (we_w),
    .drain_start         (drain_start),
    .out_ready           (out_ready),
    .out_valid           (out_valid),
    .out_data            (out_data),
    .out_row             (out_row),
    .out_column          (out_column),
    .out_last            (out_last),
    .busy                (busy),
    .write_error         (write_error)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-lane signed saturating add, done with plain integer arithmetic.
  function automatic int model_add(input int stored, input int addend, input int bw);
    int w, lanes, res, mask, a, d, s, hi, lo;
    w     = (bw == 1) ? 4 : (bw == 2) ? 2 : 8;
    lanes = 8 / w;
    mask  = (1 << w) - 1;
    hi    = (1 << (w - 1)) - 1;
    lo    = -(1 << (w - 1));
    res   = 0;
    for (int l = 0; l < lanes; l++) begin
      a = (stored >> (l * w)) & mask;
      d = (addend >> (l * w)) & mask;
      if (a > hi) a -= (1 << w);
      if (d > hi) d -= (1 << w);
      s = a + d;
      if (s > hi) s = hi;
      if (s < lo) s = lo;
      res |= (s & mask) << (l * w);
    end
    return res;
  endfunction

  function automatic int col_for_bank(input int b, input int r, input int k);
    return (((b - 3 * r) % BC) + BC) % BC + BC * k;
  endfunction

  task automatic model_write(input int b, input int r, input int c, input int d, input int bw);
    if (((c + 3 * r) % BC) != b) exp_err = 1'b1;
    else model[r][c] = model_add(model[r][c], d, bw);
  endtask

  task automatic model_zero();
    for (int r = 0; r < TS; r++)
      for (int c = 0; c < TS; c++) model[r][c] = 0;
  endtask

  task automatic idle_inputs();
    for (int b = 0; b < BC; b++) begin
      we_w[b]   = 1'b0;
      row_w[b]  = '0;
      col_w[b]  = '0;
      data_w[b] = '0;
      prev_v[b] = 1'b0;
    end
  endtask

  task automatic put_write(input int b, input int r, input int c, input int d);
    we_w[b]   = 1'b1;
    row_w[b]  = RW'(r);
    col_w[b]  = RW'(c);
    data_w[b] = 8'(d);
    model_write(b, r, c, d, int'(bitwidth));
  endtask

  // One cycle of random writes; repeats a bank's previous cell sometimes to hit forwarding.
  task automatic rand_inputs(input bit allow_bad);
    int r, c, d;
    bitwidth = 2'($urandom_range(0, 3));
    for (int b = 0; b < BC; b++) begin
      we_w[b] = ($urandom_range(0, 2) != 0);
      if (prev_v[b] && $urandom_range(0, 2) == 0) begin
        r = prev_r[b];
        c = prev_c[b];
      end else begin
        r = $urandom_range(0, TS - 1);
        c = col_for_bank(b, r, $urandom_range(0, TS / BC - 1));
        if (allow_bad && $urandom_range(0, 19) == 0) c = (c + 1) % TS;
      end
      d = $urandom_range(0, 255);
      row_w[b]  = RW'(r);
      col_w[b]  = RW'(c);
      data_w[b] = 8'(d);
      prev_v[b] = we_w[b];
      prev_r[b] = r;
      prev_c[b] = c;
      if (we_w[b]) model_write(b, r, c, d, int'(bitwidth));
    end
  endtask

  // Counts cycles until busy drops; optionally pokes a write while CLEAR runs.
  task automatic wait_clear(input bit inject);
    int cnt;
    cnt = 0;
    while (busy && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (inject && cnt == 1) begin
        we_w[0]   = 1'b1;
        row_w[0]  = '0;
        col_w[0]  = '0;
        data_w[0] = 8'h07;
        exp_err   = 1'b1;
      end
      if (cnt == 2) idle_inputs();
    end
    check("clear_busy_cycles", cnt, DEPTH);
  endtask

  // Pulses drain_start (with whatever writes the caller set up) and collects
  // stop_at elements. mode 1 drives out_ready with the pattern 1,0,0,1.
  task automatic do_drain(input int mode, input int stop_at, input bit stray);
    int got, cyc, er, ec;
    bit stall;
    logic [7:0] s_data;
    logic [RW-1:0] s_row, s_col;
    logic s_last;
    got = 0; cyc = 0; stall = 1'b0;
    s_data = '0; s_row = '0; s_col = '0; s_last = 1'b0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    idle_inputs();
    if (stray) begin
      we_w[0]   = 1'b1;
      row_w[0]  = '0;
      col_w[0]  = '0;
      data_w[0] = 8'h01;
      exp_err   = 1'b1;
    end
    while (got < stop_at && cyc < 4000) begin
      out_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (stall) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(s_data));
        check("hold_row", 32'(out_row), 32'(s_row));
        check("hold_col", 32'(out_column), 32'(s_col));
        check("hold_last", 32'(out_last), 32'(s_last));
      end
      if (out_valid && out_ready) begin
        er = got / TS;
        ec = got % TS;
        check($sformatf("drain_row[%0d]", got), 32'(out_row), 32'(er));
        check($sformatf("drain_col[%0d]", got), 32'(out_column), 32'(ec));
        check($sformatf("drain_data[%0d,%0d]", er, ec), 32'(out_data), 32'(model[er][ec]));
        check($sformatf("drain_last[%0d]", got), 32'(out_last), 32'(got == N - 1));
        model[er][ec] = 0;
        got++;
      end
      stall  = out_valid && !out_ready;
      s_data = out_data;
      s_row  = out_row;
      s_col  = out_column;
      s_last = out_last;
      @(negedge clk);
      cyc++;
      if (cyc == 1) idle_inputs();
    end
    check("drain_count", got, stop_at);
    out_ready = 1'b1;
    if (stop_at == N) begin
      check("drain_end_valid", 32'(out_valid), 0);
      check("drain_end_busy", 32'(busy), 0);
    end
  endtask

  initial begin
    idle_inputs();
    model_zero();
    exp_err = 1'b0;

    // Reset state, then CLEAR length.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 1);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_write_error", 32'(write_error), 0);
    reset_n = 1'b1;
    wait_clear(1'b0);

    // Freshly cleared tile drains as all zeros.
    do_drain(0, N, 1'b0);
    check("err_after_first_drain", 32'(write_error), 32'(exp_err));

    // Back-to-back adds to (1,2) on bank 1, 8-bit lanes.
    bitwidth = 2'b00;
    repeat (3) begin
      idle_inputs();
      put_write(1, 1, 2, 5);
      @(negedge clk);
    end
    idle_inputs();
    // 4-bit lanes on (0,0): 0x77, 0x11, 0x88 on consecutive cycles.
    bitwidth = 2'b01;
    put_write(0, 0, 0, 8'h77);
    @(negedge clk);
    put_write(0, 0, 0, 8'h11);
    @(negedge clk);
    put_write(0, 0, 0, 8'h88);
    @(negedge clk);
    idle_inputs();
    // (0,1) belongs to bank 1, presented on bank 0: dropped.
    bitwidth = 2'b00;
    put_write(0, 0, 1, 8'h33);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    check("err_wrong_bank", 32'(write_error), 32'(exp_err));
    do_drain(0, N, 1'b0);

    // Random accumulation, then a throttled drain and a second (empty) drain.
    repeat (150) begin
      rand_inputs(1'b1);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    do_drain(1, N, 1'b0);
    do_drain(1, N, 1'b0);
    check("err_after_random", 32'(write_error), 32'(exp_err));

    // Drain requested alongside in-flight writes, with a stray write while busy.
    repeat (60) begin
      rand_inputs(1'b0);
      @(negedge clk);
    end
    rand_inputs(1'b0);
    do_drain(0, N, 1'b1);
    check("err_write_while_draining", 32'(write_error), 32'(exp_err));

    // Reset in the middle of a drain.
    repeat (40) begin
      rand_inputs(1'b0);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
    do_drain(0, 20, 1'b0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_last", 32'(out_last), 0);
    check("mid_rst_data", 32'(out_data), 0);
    check("mid_rst_row", 32'(out_row), 0);
    check("mid_rst_col", 32'(out_column), 0);
    check("mid_rst_busy", 32'(busy), 1);
    check("mid_rst_write_error", 32'(write_error), 0);
    model_zero();
    exp_err = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_clear(1'b1);
    check("err_write_in_clear", 32'(write_error), 32'(exp_err));
    do_drain(1, N, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
